// File: rtl/mul_bus_pkg.sv
// Shared types and helpers for the multiplier bus master.
// Holds the FSM state encoding, register addresses and the per-state phase length.
// Imported by the top-level FSM; the phase timer is type-agnostic.
package mul_bus_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      WA_SETUP  = 4'd1,
      WA_PULSE  = 4'd2,
      WA_HOLD   = 4'd3,
      WA_GAP    = 4'd4,
      WB_SETUP  = 4'd5,
      WB_PULSE  = 4'd6,
      WB_HOLD   = 4'd7,
      WB_GAP    = 4'd8,
      RL_SETTLE = 4'd9,
      RL_GAP    = 4'd10,
      RH_SETTLE = 4'd11,
      RH_GAP    = 4'd12,
      DONE      = 4'd13
   } state_t;

   localparam logic ADDR_A  = 1'b0;
   localparam logic ADDR_B  = 1'b1;
   localparam logic ADDR_LO = 1'b0;
   localparam logic ADDR_HI = 1'b1;

   // Number of cycles spent in a state; untimed states (IDLE, DONE, gaps) report 1.
   function automatic int phase_len(input state_t s, input int setup_c, input int pulse_c,
                                    input int hold_c, input int settle_c);
      case (s)
         WA_SETUP, WB_SETUP:   phase_len = setup_c;
         WA_PULSE, WB_PULSE:   phase_len = pulse_c;
         WA_HOLD,  WB_HOLD:    phase_len = hold_c;
         RL_SETTLE, RH_SETTLE: phase_len = settle_c;
         default:              phase_len = 1;
      endcase
   endfunction

endpackage

// File: rtl/mul_bus_phase_timer.sv
// Loadable down-counter that paces each bus phase.
// Reloads on i_load, then counts down to 1 and parks there; o_done is high at count 1.
// No handshake: the FSM loads it on every state entry.
module mul_bus_phase_timer #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [CW-1:0] i_len,
   output logic          o_done
);

   logic [CW-1:0] r_cnt;

   // Reload on state entry, otherwise count down and stop at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= CW'(1);
      end else if (i_load) begin
         r_cnt <= i_len;
      end else if (r_cnt > CW'(1)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/mul_bus_master.sv
// Drives the 8x8 multiplier's async bus: write A, write B, read lo, read hi.
// Latency accept->out_valid = 2*(SETUP+PULSE+HOLD+1) + 2*(SETTLE+1) cycles (16 by default).
// in_ready only in IDLE; a stalled out_ready parks the FSM in DONE with the bus idle.
module mul_bus_master
   import mul_bus_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int PULSE_CYC  = 2,
   parameter int HOLD_CYC   = 1,
   parameter int SETTLE_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_prod,
   output logic        busy,
   output logic        bus_cs_n,
   output logic        bus_rd_n,
   output logic        bus_wr_n,
   output logic        bus_addr,
   output logic [7:0]  bus_dout,
   input  logic [7:0]  bus_din
);

   localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_HS = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
   localparam int MAX_P  = (MAX_SP > MAX_HS) ? MAX_SP : MAX_HS;
   localparam int CW     = $clog2(MAX_P) + 1;

   state_t       r_state;
   state_t       w_nxt;
   logic         w_done;
   logic         w_load;
   logic [CW-1:0] w_len;
   logic [7:0]   r_a, r_b, r_lo, r_hi;
   logic [7:0]   w_a;
   logic         r_cs_n, r_rd_n, r_wr_n, r_addr;
   logic [7:0]   r_dout;
   logic         w_cs_n, w_rd_n, w_wr_n, w_addr;
   logic [7:0]   w_dout;

   assign w_load = (w_nxt != r_state);
   assign w_len  = CW'(phase_len(w_nxt, SETUP_CYC, PULSE_CYC, HOLD_CYC, SETTLE_CYC));

   mul_bus_phase_timer #(.CW(CW)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_len  (w_len),
      .o_done (w_done)
   );

   // Next state: timed states step through the sequence in enum order when the phase expires.
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_nxt = WA_SETUP;
         DONE:    if (out_ready) w_nxt = IDLE;
         default: if (w_done)    w_nxt = state_t'(r_state + 4'd1);
      endcase
   end

   // Operand A is taken straight from the input on the accept edge, since r_a loads on that same edge.
   assign w_a = (r_state == IDLE) ? in_a : r_a;

   // Bus pin values for the state being entered; registered below so strobes never glitch.
   always_comb begin
      w_cs_n = 1'b1;
      w_rd_n = 1'b1;
      w_wr_n = 1'b1;
      w_addr = ADDR_A;
      w_dout = 8'h00;
      case (w_nxt)
         WA_SETUP, WA_HOLD: begin w_cs_n = 1'b0; w_dout = w_a; end
         WA_PULSE:          begin w_cs_n = 1'b0; w_wr_n = 1'b0; w_dout = w_a; end
         WA_GAP:            w_dout = w_a;
         WB_SETUP, WB_HOLD: begin w_cs_n = 1'b0; w_addr = ADDR_B; w_dout = r_b; end
         WB_PULSE:          begin w_cs_n = 1'b0; w_wr_n = 1'b0; w_addr = ADDR_B; w_dout = r_b; end
         WB_GAP:            begin w_addr = ADDR_B; w_dout = r_b; end
         RL_SETTLE:         begin w_cs_n = 1'b0; w_rd_n = 1'b0; w_addr = ADDR_LO; end
         RL_GAP:            w_addr = ADDR_LO;
         RH_SETTLE:         begin w_cs_n = 1'b0; w_rd_n = 1'b0; w_addr = ADDR_HI; end
         RH_GAP:            w_addr = ADDR_HI;
         default:           ;
      endcase
   end

   // State, registered bus pins, captured operands and read-back product bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cs_n  <= 1'b1;
         r_rd_n  <= 1'b1;
         r_wr_n  <= 1'b1;
         r_addr  <= 1'b0;
         r_dout  <= 8'h00;
         r_a     <= 8'h00;
         r_b     <= 8'h00;
         r_lo    <= 8'h00;
         r_hi    <= 8'h00;
      end else begin
         r_state <= w_nxt;
         r_cs_n  <= w_cs_n;
         r_rd_n  <= w_rd_n;
         r_wr_n  <= w_wr_n;
         r_addr  <= w_addr;
         r_dout  <= w_dout;
         if (r_state == IDLE && in_valid) begin
            r_a <= in_a;
            r_b <= in_b;
         end
         if (r_state == RL_SETTLE && w_done) r_lo <= bus_din;
         if (r_state == RH_SETTLE && w_done) r_hi <= bus_din;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign out_prod  = {r_hi, r_lo};
   assign bus_cs_n  = r_cs_n;
   assign bus_rd_n  = r_rd_n;
   assign bus_wr_n  = r_wr_n;
   assign bus_addr  = r_addr;
   assign bus_dout  = r_dout;

endmodule

// File: tb/tb_mul_bus_master.sv
// Bench for mul_bus_master: default instance plus a stretched-timing instance.
// Each instance talks to a behavioural multiplier on its bus.
// Protocol monitors count strobe/stability violations, which are checked at the end.
module tb_mul_bus_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        iv[2], ir[2], ov[2], ordy[2], bsy[2];
   logic        cs[2], rd[2], wr[2], ad[2];
   logic [7:0]  ia[2], ib[2], dout[2], din[2];
   logic [15:0] op[2];

   int n_chk  = 0;
   int n_fail = 0;

   mul_bus_master dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_prod(op[0]), .busy(bsy[0]), .bus_cs_n(cs[0]), .bus_rd_n(rd[0]),
      .bus_wr_n(wr[0]), .bus_addr(ad[0]), .bus_dout(dout[0]), .bus_din(din[0])
   );

   mul_bus_master #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2), .SETTLE_CYC(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_prod(op[1]), .busy(bsy[1]), .bus_cs_n(cs[1]), .bus_rd_n(rd[1]),
      .bus_wr_n(wr[1]), .bus_addr(ad[1]), .bus_dout(dout[1]), .bus_din(din[1])
   );

   // Behavioural peripheral and protocol monitor per instance.
   for (genvar g = 0; g < 2; g++) begin : g_bus
      logic [7:0]  ra = 8'h00;
      logic [7:0]  rb = 8'h00;
      logic [15:0] prod;
      int          viol = 0;
      int          run  = 0;
      logic        last_ad = 1'b0;
      int          q_len[$];
      logic        q_addr[$];
      logic        p_cs = 1'b1;
      logic        p_ad = 1'b0;
      logic [7:0]  p_do = 8'h00;

      assign prod   = 16'(ra) * 16'(rb);
      assign din[g] = (!cs[g] && !rd[g]) ? (ad[g] ? prod[15:8] : prod[7:0]) : 8'h00;

      always @(posedge wr[g]) begin
         if (!cs[g]) begin
            if (ad[g]) rb <= dout[g];
            else       ra <= dout[g];
         end
      end

      always @(negedge clk) begin
         if (!wr[g] && !rd[g]) viol++;
         if (cs[g] && (!wr[g] || !rd[g])) viol++;
         if (!cs[g] && !p_cs && (ad[g] !== p_ad || dout[g] !== p_do)) viol++;
         p_cs = cs[g];
         p_ad = ad[g];
         p_do = dout[g];
         if (!wr[g]) begin
            run++;
            last_ad = ad[g];
         end else if (run != 0) begin
            q_len.push_back(run);
            q_addr.push_back(last_ad);
            run = 0;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // One full operation on instance u; returns product and accept->out_valid latency.
   task automatic run_op(input int u, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] prod, output int lat);
      int t = 0;
      ia[u] = a;
      ib[u] = b;
      iv[u] = 1'b1;
      while (!ir[u] && t < 200) begin
         @(posedge clk); #1; t++;
      end
      check("accept_wait", 32'(t < 200), 32'd1);
      @(posedge clk); #1;
      iv[u] = 1'b0;
      lat = 0;
      while (!ov[u] && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      prod    = op[u];
      ordy[u] = 1'b1;
      @(posedge clk); #1;
      ordy[u] = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   vec_t        vt[8];
   logic [15:0] expq[$];
   int          rcvd = 0;
   int          bad  = 0;
   logic        prod_stop = 1'b0;

   initial begin
      logic [15:0] p;
      int          lat;
      int          q0;
      int          t;

      vt[0] = '{8'h0C, 8'h0D, 16'h009C};
      vt[1] = '{8'hFF, 8'hFF, 16'hFE01};
      vt[2] = '{8'h00, 8'hA5, 16'h0000};
      vt[3] = '{8'h12, 8'h34, 16'h03A8};
      vt[4] = '{8'h01, 8'h01, 16'h0001};
      vt[5] = '{8'h80, 8'h02, 16'h0100};
      vt[6] = '{8'hFF, 8'h01, 16'h00FF};
      vt[7] = '{8'hA5, 8'h5A, 16'h3A02};

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b0; ia[i] = 8'h00; ib[i] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", 32'(cs[0]), 32'd1);
      check("rst_rd_n", 32'(rd[0]), 32'd1);
      check("rst_wr_n", 32'(wr[0]), 32'd1);
      check("rst_addr", 32'(ad[0]), 32'd0);
      check("rst_dout", 32'(dout[0]), 32'd0);
      check("rst_out_valid", 32'(ov[0]), 32'd0);
      check("rst_out_prod", 32'(op[0]), 32'd0);
      check("rst_busy", 32'(bsy[0]), 32'd0);
      check("rst_in_ready", 32'(ir[0]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table of directed operand pairs on the default instance.
      q0 = g_bus[0].q_len.size();
      for (int i = 0; i < 8; i++) begin
         run_op(0, vt[i].a, vt[i].b, p, lat);
         check($sformatf("vec%0d_prod", i), 32'(p), 32'(vt[i].exp));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
      end
      check("wrA_pulse_len", 32'(g_bus[0].q_len[q0]), 32'd2);
      check("wrA_addr", 32'(g_bus[0].q_addr[q0]), 32'd0);
      check("wrB_pulse_len", 32'(g_bus[0].q_len[q0+1]), 32'd2);
      check("wrB_addr", 32'(g_bus[0].q_addr[q0+1]), 32'd1);

      // Back-to-back with out_ready high: second accept one cycle after the result handshake.
      ordy[0] = 1'b1;
      ia[0] = 8'hFF; ib[0] = 8'hFF; iv[0] = 1'b1;
      check("b2b_ready1", 32'(ir[0]), 32'd1);
      @(posedge clk); #1;
      lat = 0;
      while (!ov[0] && lat < 200) begin @(posedge clk); #1; lat++; end
      check("b2b_lat1", 32'(lat), 32'd16);
      check("b2b_prod1", 32'(op[0]), 32'hFE01);
      ia[0] = 8'h00; ib[0] = 8'hA5;
      @(posedge clk); #1;
      check("b2b_ready2", 32'(ir[0]), 32'd1);
      check("b2b_valid_drop", 32'(ov[0]), 32'd0);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      check("b2b_accept2", 32'(bsy[0]), 32'd1);
      lat = 0;
      while (!ov[0] && lat < 200) begin @(posedge clk); #1; lat++; end
      check("b2b_lat2", 32'(lat), 32'd16);
      check("b2b_prod2", 32'(op[0]), 32'h0000);
      @(posedge clk); #1;
      ordy[0] = 1'b0;

      // Result held off for 10 cycles: output stable, bus idle, no accept.
      ia[0] = 8'h0B; ib[0] = 8'h0B; iv[0] = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!ov[0] && lat < 200) begin @(posedge clk); #1; lat++; end
      check("hold_lat", 32'(lat), 32'd16);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("hold_prod", 32'(op[0]), 32'h0079);
         check("hold_valid", 32'(ov[0]), 32'd1);
         check("hold_in_ready", 32'(ir[0]), 32'd0);
         check("hold_bus_idle", 32'({cs[0], rd[0], wr[0]}), 32'h7);
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      check("release_in_ready", 32'(ir[0]), 32'd1);
      check("release_valid", 32'(ov[0]), 32'd0);

      // Reset during the operand-B write pulse.
      ia[0] = 8'h55; ib[0] = 8'h66; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      t = 0;
      while (!(!wr[0] && ad[0]) && t < 50) begin @(posedge clk); #1; t++; end
      check("reach_wb_pulse", 32'(t < 50), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_cs_n", 32'(cs[0]), 32'd1);
      check("arst_rd_n", 32'(rd[0]), 32'd1);
      check("arst_wr_n", 32'(wr[0]), 32'd1);
      check("arst_addr", 32'(ad[0]), 32'd0);
      check("arst_dout", 32'(dout[0]), 32'd0);
      check("arst_out_valid", 32'(ov[0]), 32'd0);
      check("arst_busy", 32'(bsy[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_in_ready", 32'(ir[0]), 32'd1);
      run_op(0, 8'h12, 8'h34, p, lat);
      check("post_rst_prod", 32'(p), 32'h03A8);
      check("post_rst_lat", 32'(lat), 32'd16);

      // Stretched timing instance.
      q0 = g_bus[1].q_len.size();
      run_op(1, 8'h0C, 8'h0D, p, lat);
      check("slow_prod", 32'(p), 32'h009C);
      check("slow_lat", 32'(lat), 32'd24);
      check("slow_wr_pulse_len", 32'(g_bus[1].q_len[q0]), 32'd1);
      run_op(1, 8'hFF, 8'hFE, p, lat);
      check("slow_prod2", 32'(p), 32'hFD02);
      check("slow_lat2", 32'(lat), 32'd24);

      // Random stream with random gaps on both handshakes.
      fork
         begin
            for (int k = 0; k < 1000 && !prod_stop; k++) begin
               int          t2;
               logic [7:0]  ua, ub;
               t2 = 0;
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               ua = 8'($urandom);
               ub = 8'($urandom);
               ia[0] = ua; ib[0] = ub; iv[0] = 1'b1;
               while (!ir[0] && t2 < 1000) begin @(posedge clk); #1; t2++; end
               if (t2 >= 1000) begin
                  prod_stop = 1'b1;
                  iv[0] = 1'b0;
               end else begin
                  @(posedge clk);
                  expq.push_back(16'(ua) * 16'(ub));
                  #1;
                  iv[0] = 1'b0;
               end
            end
         end
         begin
            int cyc;
            cyc = 0;
            while (rcvd < 1000 && cyc < 60000) begin
               ordy[0] = ($urandom_range(0, 3) != 0);
               if (ov[0] && ordy[0]) begin
                  if (expq.size() == 0 || op[0] !== expq[0]) bad++;
                  if (expq.size() != 0) void'(expq.pop_front());
                  rcvd++;
               end
               @(posedge clk); #1;
               cyc++;
            end
            ordy[0] = 1'b0;
         end
      join
      check("rnd_mismatches", 32'(bad), 32'd0);
      check("rnd_received", 32'(rcvd), 32'd1000);
      check("rnd_leftover", 32'(expq.size()), 32'd0);

      check("protocol_viol_dut", 32'(g_bus[0].viol), 32'd0);
      check("protocol_viol_dut2", 32'(g_bus[1].viol), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_bus_master.md
Name: mul_bus_master

Overview:
- Synchronous upstream driver for the 8x8 multiplier peripheral's asynchronous parallel bus (chip select, read and write strobes, address line, data).
- Accepts an operand pair on a valid/ready stream.
- Performs two strobed writes, operand A at address 0 and operand B at address 1, then two reads: product low byte at address 0, high byte at address 1.
- Returns the 16-bit product on a valid/ready result stream.
- Sits between a host-side sequencer and the multiplier pins; all strobe timing is generated from clk.

Parameters:
- SETUP_CYC, 1, cycles cs_n low with addr/dout stable before wr_n falls (>=1).
- PULSE_CYC, 2, cycles wr_n held low (>=1).
- HOLD_CYC, 1, cycles cs_n/addr/dout held after wr_n rises (>=1).
- SETTLE_CYC, 2, cycles cs_n/rd_n low before bus_din is sampled (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  8  operand A.
- in_b  in  8  operand B.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_prod  out  16  product {hi,lo} as read back from the bus.
- busy  out  1  high in any state other than IDLE.
- bus_cs_n  out  1  chip select, active low.
- bus_rd_n  out  1  read strobe, active low.
- bus_wr_n  out  1  write strobe, active low; the peripheral latches on its rising edge.
- bus_addr  out  1  register select.
- bus_dout  out  8  write data.
- bus_din  in  8  read data from the peripheral.

Behaviour:
- Reset (async, immediate):
  - bus_cs_n=1, bus_rd_n=1, bus_wr_n=1, bus_addr=0, bus_dout=0.
  - out_valid=0, out_prod=0, busy=0; state IDLE, so in_ready=1.
  - Reset asserted during a write pulse drives wr_n high at once. The peripheral may latch that edge; this is accepted, and the host must rewrite both operands after reset.
- All bus outputs are registered, so there are no glitches on strobes.
- States: IDLE, WA_SETUP, WA_PULSE, WA_HOLD, WA_GAP, WB_SETUP, WB_PULSE, WB_HOLD, WB_GAP, RL_SETTLE, RL_GAP, RH_SETTLE, RH_GAP, DONE.
- Handshakes:
  - in_ready = (state==IDLE). Accept occurs on in_valid&&in_ready; in_a/in_b are captured and the FSM enters WA_SETUP.
  - out_valid = (state==DONE). out_prod is stable while out_valid is high. On out_valid&&out_ready, go to IDLE. in_ready is not asserted in that same cycle, so the minimum issue interval is latency+1.
- Write phase X in {A,B}, with addr 0 for A and 1 for B:
  - SETUP: cs_n=0, wr_n=1, addr and dout valid, for SETUP_CYC cycles.
  - PULSE: wr_n=0 for PULSE_CYC cycles.
  - HOLD: wr_n=1, cs_n=0 for HOLD_CYC cycles.
  - GAP: cs_n=1 for 1 cycle.
  - dout and addr never change while cs_n=0.
- Read phase, addr 0 for lo and 1 for hi:
  - SETTLE: cs_n=0, rd_n=0 for SETTLE_CYC cycles; bus_din is sampled on the clock edge ending the last SETTLE cycle.
  - GAP: cs_n=1, rd_n=1 for 1 cycle.
  - bus_dout is driven to 0 during reads.
- The phase counter reloads on each state entry and counts down to 1. Width is $clog2(max param)+1.
- rd_n and wr_n are never low simultaneously. cs_n is high for at least 1 cycle between accesses.
- Latency from the accept edge to out_valid: 2*(SETUP_CYC+PULSE_CYC+HOLD_CYC+1) + 2*(SETTLE_CYC+1) cycles. This is 16 with defaults.
- in_valid changing or dropping while busy is ignored, because the operands are already captured.
- A held-off out_ready leaves the FSM in DONE indefinitely; no new operands are accepted.

Decomposition:
- Package mul_bus_pkg contains:
  - state enum type.
  - localparams ADDR_A=1'b0, ADDR_B=1'b1, ADDR_LO=1'b0, ADDR_HI=1'b1.
  - a function returning the phase length for a given state.
- One sub-module, mul_bus_phase_timer: a loadable down-counter with a done flag. It keeps the FSM free of counter arithmetic.

Test Plan:
- Defaults; a=0x0C, b=0x0D against a behavioural multiplier model on the bus -> out_prod=0x009C, out_valid exactly 16 cycles after accept. The strobe trace must show wr_n low for exactly 2 cycles each write, addr 0 then 1.
- a=0xFF, b=0xFF -> out_prod=0xFE01. Then a=0x00, b=0xA5 -> 0x0000. Both with out_ready tied high; the second accept lands at the earliest allowed cycle.
- Parameters SETUP=3, PULSE=1, HOLD=2, SETTLE=4 -> latency 2*7+2*5=24. Assertions check cs_n/addr/dout stable for the whole cs_n-low window and rd_n/wr_n never both low.
- out_ready held low 10 cycles after out_valid -> out_prod stable, in_ready=0, no bus activity; releasing out_ready returns to IDLE next cycle.
- rst_n pulsed low during WB_PULSE -> all bus outputs idle the same cycle, out_valid=0, in_ready=1 after release. A fresh operation a=0x12, b=0x34 then yields 0x03A8.
- Random 1000 operand pairs with random in_valid/out_ready gaps -> every product equals a*b, no lost or duplicated results.
